// File: rtl/rate_cmd_pkg.sv
// Shared constants for the rate command path: ASCII bytes, rate codes and parser states.
// Used by the receive parser, the status transmitter and the rate selector.
package rate_cmd_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_R     = 8'h72;
    localparam logic [7:0] ASCII_A     = 8'h61;
    localparam logic [7:0] ASCII_T     = 8'h74;
    localparam logic [7:0] ASCII_E     = 8'h65;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_5     = 8'h35;

    localparam logic [7:0] CASE_FOLD   = 8'h20;

    localparam logic [1:0] RATE_1 = 2'b00;
    localparam logic [1:0] RATE_5 = 2'b01;
    localparam logic [1:0] RATE_A = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KEYWORD = 3'd1,
        ST_ARG     = 3'd2,
        ST_TERM    = 3'd3,
        ST_FLUSH   = 3'd4
    } parser_state_e;

    // Keyword positions 1..3 are letters (case-folded); position 4 is ':' and must match exactly.
    function automatic logic keyword_match(input logic [2:0] idx, input logic [7:0] data);
        logic [7:0] folded;
        logic       hit;
        folded = data | CASE_FOLD;
        hit    = 1'b0;
        case (idx)
            3'd1:    hit = (folded == ASCII_A);
            3'd2:    hit = (folded == ASCII_T);
            3'd3:    hit = (folded == ASCII_E);
            3'd4:    hit = (data == ASCII_COLON);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/rx_byte_timer.sv
// Inter-byte timeout counter: counts enabled cycles, clears on a byte or on expiry.
// Only instantiated when RX_CMD_TIMEOUT_EN is defined.
module rx_byte_timer #(
    parameter int unsigned LIMIT = 5_000_000,
    parameter int unsigned TMR_W = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMR_W-1:0] count;

    // Expiry fires on the LIMIT-th consecutive enabled cycle.
    assign expire = enable && (count == TMR_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_rate_cmd_parser.sv
// Parses "rate:<1|5|a>\n" from the UART byte stream and updates the 2-bit rate code.
// Optional inter-byte timeout is built when RX_CMD_TIMEOUT_EN is defined.
module rx_rate_cmd_parser
    import rate_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 5_000_000,
    parameter int unsigned TMR_W       = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iRX_VALID,
    input  logic [7:0]    iRX_DATA,
    output logic [1:0]    oRATE,
    output logic          oRATE_UPDATE,
    output logic          oCMD_ERR,
    output logic          oBUSY,
    output parser_state_e dbg_state
);

    // iRX_VALID is a one-cycle strobe with no back-pressure: every cycle it is high
    // carries a new byte and the parser consumes it on that edge, with no dead cycles.

    parser_state_e state;
    logic [2:0]    idx;
    logic [1:0]    pending;
    logic [7:0]    folded;
    logic          timeout;

    assign folded    = iRX_DATA | CASE_FOLD;
    assign oBUSY     = (state != ST_IDLE);
    assign dbg_state = state;

`ifdef RX_CMD_TIMEOUT_EN
    logic timer_en;

    assign timer_en = (state == ST_KEYWORD) || (state == ST_ARG) || (state == ST_TERM);

    rx_byte_timer #(
        .LIMIT (TIMEOUT_CYC),
        .TMR_W (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (iRX_VALID),
        .enable (timer_en),
        .expire (timeout)
    );
`else
    localparam int unsigned unused_timeout_cfg = TIMEOUT_CYC + TMR_W;

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            pending      <= RATE_1;
            oRATE        <= RATE_1;
            oRATE_UPDATE <= 1'b0;
            oCMD_ERR     <= 1'b0;
        end else begin
            oRATE_UPDATE <= 1'b0;
            oCMD_ERR     <= 1'b0;

            if (iRX_VALID && (iRX_DATA != ASCII_CR)) begin
                unique case (state)
                    ST_IDLE: begin
                        if ((iRX_DATA == ASCII_SPACE) || (iRX_DATA == ASCII_LF)) begin
                            state <= ST_IDLE;
                        end else if (folded == ASCII_R) begin
                            state <= ST_KEYWORD;
                            idx   <= 3'd1;
                        end else begin
                            state    <= ST_FLUSH;
                            oCMD_ERR <= 1'b1;
                        end
                    end

                    ST_KEYWORD: begin
                        if (iRX_DATA == ASCII_LF) begin
                            state    <= ST_IDLE;
                            idx      <= '0;
                            oCMD_ERR <= 1'b1;
                        end else if (keyword_match(idx, iRX_DATA)) begin
                            if (idx == 3'd4) begin
                                state <= ST_ARG;
                                idx   <= '0;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end else begin
                            state    <= ST_FLUSH;
                            idx      <= '0;
                            oCMD_ERR <= 1'b1;
                        end
                    end

                    ST_ARG: begin
                        if (iRX_DATA == ASCII_1) begin
                            pending <= RATE_1;
                            state   <= ST_TERM;
                        end else if (iRX_DATA == ASCII_5) begin
                            pending <= RATE_5;
                            state   <= ST_TERM;
                        end else if (folded == ASCII_A) begin
                            pending <= RATE_A;
                            state   <= ST_TERM;
                        end else if (iRX_DATA == ASCII_LF) begin
                            state    <= ST_IDLE;
                            oCMD_ERR <= 1'b1;
                        end else begin
                            state    <= ST_FLUSH;
                            oCMD_ERR <= 1'b1;
                        end
                    end

                    ST_TERM: begin
                        if (iRX_DATA == ASCII_LF) begin
                            oRATE        <= pending;
                            oRATE_UPDATE <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            state    <= ST_FLUSH;
                            oCMD_ERR <= 1'b1;
                        end
                    end

                    ST_FLUSH: begin
                        if (iRX_DATA == ASCII_LF) begin
                            state <= ST_IDLE;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end
                endcase
            end else if (!iRX_VALID && timeout) begin
                // A stalled partial command is dropped; the rate code is left alone.
                state    <= ST_IDLE;
                idx      <= '0;
                oCMD_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_rate_cmd_parser.sv
// Bench for rx_rate_cmd_parser: byte-level reference model built on command-prefix matching.
// Timeout scenario is included when RX_CMD_TIMEOUT_EN is defined.
module tb_rx_rate_cmd_parser;

    localparam int TB_TIMEOUT = 100;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [1:0] rate;
    logic       rate_update;
    logic       cmd_err;
    logic       busy;
    rate_cmd_pkg::parser_state_e dbg_state;

    rx_rate_cmd_parser #(
        .TIMEOUT_CYC (TB_TIMEOUT),
        .TMR_W       (23)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .iRX_VALID    (rx_valid),
        .iRX_DATA     (rx_data),
        .oRATE        (rate),
        .oRATE_UPDATE (rate_update),
        .oCMD_ERR     (cmd_err),
        .oBUSY        (busy),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model state: the text of the command line received so far.
    logic [7:0] line_q[$];
    bit         flushing;
    int         idle_cnt;
    logic [1:0] exp_rate;
    logic       exp_upd;
    logic       exp_err;
    logic       exp_busy;
    logic [1:0] exp_q[$];
    cyc_t       plan_q[$];
    int         checks;
    int         failures;

    function automatic bit char_ok(input logic [7:0] c, input int pos, input logic [7:0] arg);
        logic [7:0] want;
        case (pos)
            0: want = "r";
            1: want = "a";
            2: want = "t";
            3: want = "e";
            4: want = ":";
            default: want = arg;
        endcase
        if (want >= "a" && want <= "z") return (c | 8'h20) == want;
        return c == want;
    endfunction

    // True when the current line is a prefix of some legal command.
    function automatic bit line_is_prefix();
        logic [7:0] args[3];
        bit ok;
        args = '{"1", "5", "a"};
        if (line_q.size() > 6) return 1'b0;
        for (int t = 0; t < 3; t++) begin
            ok = 1'b1;
            for (int i = 0; i < line_q.size(); i++)
                if (!char_ok(line_q[i], i, args[t])) ok = 1'b0;
            if (ok) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] arg_code(input logic [7:0] c);
        if (c == "1") return 2'b00;
        if (c == "5") return 2'b01;
        return 2'b10;
    endfunction

    task automatic model_reset();
        line_q.delete();
        exp_q.delete();
        flushing = 1'b0;
        idle_cnt = 0;
        exp_rate = 2'b00;
        exp_upd  = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        exp_upd = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            idle_cnt = 0;
            if (d != 8'h0D) begin
                if (flushing) begin
                    if (d == 8'h0A) flushing = 1'b0;
                end else if (line_q.size() == 0 && (d == 8'h20 || d == 8'h0A)) begin
                    flushing = 1'b0;
                end else if (d == 8'h0A) begin
                    if (line_q.size() == 6) begin
                        exp_rate = arg_code(line_q[5]);
                        exp_upd  = 1'b1;
                        exp_q.push_back(exp_rate);
                    end else begin
                        exp_err = 1'b1;
                    end
                    line_q.delete();
                end else begin
                    line_q.push_back(d);
                    if (!line_is_prefix()) begin
                        exp_err  = 1'b1;
                        flushing = 1'b1;
                        line_q.delete();
                    end
                end
            end
        end
`ifdef RX_CMD_TIMEOUT_EN
        else if (line_q.size() != 0 && !flushing) begin
            idle_cnt++;
            if (idle_cnt == TB_TIMEOUT) begin
                exp_err  = 1'b1;
                idle_cnt = 0;
                line_q.delete();
            end
        end
`endif
        exp_busy = flushing || (line_q.size() != 0);
    endtask

    // Drives one clock cycle from a negedge and returns at the following negedge.
    task automatic step(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom_range(0, 255));
        model_step(v, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic plan_byte(input logic [7:0] b, input int max_gap);
        int gap;
        plan_q.push_back('{v: 1'b1, d: b});
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) plan_q.push_back('{v: 1'b0, d: 8'h00});
    endtask

    task automatic plan_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            plan_q.push_back('{v: 1'b1, d: s[i]});
            repeat (gap) plan_q.push_back('{v: 1'b0, d: 8'h00});
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rate, rate_update, cmd_err, busy} !== 5'b0 || dbg_state !== rate_cmd_pkg::ST_IDLE) begin
            failures++;
            $display("FAIL reset_values got rate=%b upd=%b err=%b busy=%b state=%0d want all zero",
                     rate, rate_update, cmd_err, busy, dbg_state);
        end
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'h00);
            checks++;
            if ({rate, rate_update, cmd_err, busy} !== 5'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got rate=%b upd=%b err=%b busy=%b want 00/0/0/0",
                         i, rate, rate_update, cmd_err, busy);
            end
        end
    endtask

    task automatic test_spaced();
        int upd_n = 0;
        int busy_n = 0;
        plan_q.delete();
        plan_str("rate:5\n", 15);
        for (int i = 0; i < plan_q.size(); i++) begin
            step(plan_q[i].v, plan_q[i].d);
            checks++;
            if ({rate, rate_update, cmd_err, busy} !== {exp_rate, exp_upd, exp_err, exp_busy}) begin
                failures++;
                $display("FAIL spaced cyc=%0d got rate=%b upd=%b err=%b busy=%b want %b/%b/%b/%b",
                         i, rate, rate_update, cmd_err, busy, exp_rate, exp_upd, exp_err, exp_busy);
            end
            if (rate_update === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q.pop_front() !== rate) begin
                    failures++;
                    $display("FAIL spaced_sb cyc=%0d got update with rate=%b, no matching expected", i, rate);
                end
            end
            upd_n  += int'(rate_update);
            busy_n += int'(busy);
        end
        checks++;
        if (upd_n != 1 || rate !== 2'b01 || busy_n != 96) begin
            failures++;
            $display("FAIL spaced_summary got upd=%0d rate=%b busy_cycles=%0d want 1/01/96", upd_n, rate, busy_n);
        end
    endtask

    task automatic test_back_to_back();
        int upd_n = 0;
        int busy_n = 0;
        plan_q.delete();
        plan_str("RATE:a\r\n", 0);
        plan_q.push_back('{v: 1'b0, d: 8'h00});
        for (int i = 0; i < plan_q.size(); i++) begin
            step(plan_q[i].v, plan_q[i].d);
            checks++;
            if ({rate, rate_update, cmd_err, busy} !== {exp_rate, exp_upd, exp_err, exp_busy}) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got rate=%b upd=%b err=%b busy=%b want %b/%b/%b/%b",
                         i, rate, rate_update, cmd_err, busy, exp_rate, exp_upd, exp_err, exp_busy);
            end
            if (rate_update === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q.pop_front() !== rate) begin
                    failures++;
                    $display("FAIL back_to_back_sb cyc=%0d got update with rate=%b, no matching expected", i, rate);
                end
            end
            upd_n  += int'(rate_update);
            busy_n += int'(busy);
        end
        checks++;
        if (upd_n != 1 || rate !== 2'b10 || busy_n != 7) begin
            failures++;
            $display("FAIL back_to_back_summary got upd=%0d rate=%b busy_cycles=%0d want 1/10/7", upd_n, rate, busy_n);
        end
    endtask

    task automatic test_errors();
        int err_n = 0;
        int upd_n = 0;
        int first_err = -1;
        int split;
        plan_q.delete();
        plan_str("ratx:1\n", 0);
        split = plan_q.size();
        plan_str("rate:1\n", 1);
        plan_str("rate:5\n", 0);
        plan_str("rate:7\n", 0);
        plan_str("rate:\n", 2);
        plan_str("rate:55\n", 0);
        for (int i = 0; i < plan_q.size(); i++) begin
            step(plan_q[i].v, plan_q[i].d);
            checks++;
            if ({rate, rate_update, cmd_err, busy} !== {exp_rate, exp_upd, exp_err, exp_busy}) begin
                failures++;
                $display("FAIL errors cyc=%0d got rate=%b upd=%b err=%b busy=%b want %b/%b/%b/%b",
                         i, rate, rate_update, cmd_err, busy, exp_rate, exp_upd, exp_err, exp_busy);
            end
            if (rate_update === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q.pop_front() !== rate) begin
                    failures++;
                    $display("FAIL errors_sb cyc=%0d got update with rate=%b, no matching expected", i, rate);
                end
            end
            if (cmd_err === 1'b1 && first_err < 0) first_err = i;
            err_n += int'(cmd_err);
            upd_n += int'(rate_update);
            if (i == split - 1) begin
                checks++;
                if (err_n != 1 || first_err != 3 || rate !== 2'b10 || upd_n != 0) begin
                    failures++;
                    $display("FAIL ratx got errs=%0d at cyc=%0d rate=%b upd=%0d want 1 at 3, rate 10, upd 0",
                             err_n, first_err, rate, upd_n);
                end
            end
        end
        checks++;
        if (err_n != 4 || upd_n != 2 || rate !== 2'b01) begin
            failures++;
            $display("FAIL errors_summary got errs=%0d upd=%0d rate=%b want 4/2/01", err_n, upd_n, rate);
        end
    endtask

    task automatic test_reset_mid();
        int err_n = 0;
        int upd_n = 0;
        step(1'b1, "r");
        step(1'b1, "a");
        step(1'b1, "t");
        reset = 1'b0;
        #1;
        checks++;
        if ({rate, rate_update, cmd_err, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_async got rate=%b upd=%b err=%b busy=%b want all zero",
                     rate, rate_update, cmd_err, busy);
        end
        model_reset();
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        plan_q.delete();
        plan_str("e:5\n", 0);
        plan_str("rate:5\n", 1);
        for (int i = 0; i < plan_q.size(); i++) begin
            step(plan_q[i].v, plan_q[i].d);
            checks++;
            if ({rate, rate_update, cmd_err, busy} !== {exp_rate, exp_upd, exp_err, exp_busy}) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got rate=%b upd=%b err=%b busy=%b want %b/%b/%b/%b",
                         i, rate, rate_update, cmd_err, busy, exp_rate, exp_upd, exp_err, exp_busy);
            end
            if (rate_update === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q.pop_front() !== rate) begin
                    failures++;
                    $display("FAIL reset_mid_sb cyc=%0d got update with rate=%b, no matching expected", i, rate);
                end
            end
            err_n += int'(cmd_err);
            upd_n += int'(rate_update);
        end
        checks++;
        if (err_n != 1 || upd_n != 1 || rate !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid_summary got errs=%0d upd=%0d rate=%b want 1/1/01", err_n, upd_n, rate);
        end
    endtask

    task automatic test_random();
        logic [7:0] args[3];
        logic [7:0] kw[5];
        args = '{"1", "5", "a"};
        kw   = '{"r", "a", "t", "e", ":"};
        plan_q.delete();
        for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(0, 5);
            int len  = $urandom_range(1, 6);
            logic [7:0] a;
            if ($urandom_range(0, 4) == 0) plan_byte(8'h20, 1);
            if (kind <= 2 || kind == 4 || kind == 5) begin
                for (int k = 0; k < ((kind == 5) ? ((len > 5) ? 5 : len) : 5); k++)
                    plan_byte((k < 4 && $urandom_range(0, 1) == 1) ? (kw[k] ^ 8'h20) : kw[k], 2);
            end
            if (kind <= 2) begin
                a = args[$urandom_range(0, 2)];
                if (a == "a" && $urandom_range(0, 1) == 1) a = "A";
                plan_byte(a, 2);
                if ($urandom_range(0, 3) == 0) plan_byte(8'h0D, 1);
            end else if (kind == 3) begin
                for (int k = 0; k < len; k++) plan_byte(8'($urandom_range(8'h21, 8'h7E)), 2);
            end else if (kind == 4) begin
                plan_byte(8'($urandom_range(8'h21, 8'h7E)), 2);
            end
            plan_byte(8'h0A, 3);
        end
        for (int i = 0; i < plan_q.size(); i++) begin
            step(plan_q[i].v, plan_q[i].d);
            checks++;
            if ({rate, rate_update, cmd_err, busy} !== {exp_rate, exp_upd, exp_err, exp_busy}) begin
                failures++;
                $display("FAIL random cyc=%0d data=%h got rate=%b upd=%b err=%b busy=%b want %b/%b/%b/%b",
                         i, plan_q[i].d, rate, rate_update, cmd_err, busy, exp_rate, exp_upd, exp_err, exp_busy);
            end
            if (rate_update === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q.pop_front() !== rate) begin
                    failures++;
                    $display("FAIL random_sb cyc=%0d got update with rate=%b, no matching expected", i, rate);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_missed got %0d expected updates never seen want 0", exp_q.size());
        end
    endtask

`ifdef RX_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int err_n = 0;
        plan_q.delete();
        plan_str("rat", 0);
        repeat (TB_TIMEOUT + 10) plan_q.push_back('{v: 1'b0, d: 8'h00});
        plan_str("rate:a\n", 0);
        for (int i = 0; i < plan_q.size(); i++) begin
            step(plan_q[i].v, plan_q[i].d);
            checks++;
            if ({rate, rate_update, cmd_err, busy} !== {exp_rate, exp_upd, exp_err, exp_busy}) begin
                failures++;
                $display("FAIL timeout cyc=%0d got rate=%b upd=%b err=%b busy=%b want %b/%b/%b/%b",
                         i, rate, rate_update, cmd_err, busy, exp_rate, exp_upd, exp_err, exp_busy);
            end
            if (rate_update === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q.pop_front() !== rate) begin
                    failures++;
                    $display("FAIL timeout_sb cyc=%0d got update with rate=%b, no matching expected", i, rate);
                end
            end
            err_n += int'(cmd_err);
            if (i == TB_TIMEOUT + 8) begin
                checks++;
                if (err_n != 1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_stall got errs=%0d busy=%b want 1/0", err_n, busy);
                end
            end
        end
        checks++;
        if (rate !== 2'b10 || err_n != 1) begin
            failures++;
            $display("FAIL timeout_summary got rate=%b errs=%0d want 10/1", rate, err_n);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_spaced();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_random();
`ifdef RX_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
